sev_seg_scan_ctrl: RTL



---
 rtl/sev_seg_pkg.sv | 17 +
 rtl/seven_seg_decoder.sv | 30 +++
 rtl/sev_seg_scan_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sev_seg_pkg.sv
// Shared constants for the 7-segment scan controller: register map,
// CTRL bit positions and the all-segments-off pattern.
package sev_seg_pkg;

  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_CTRL     = 2'd1,
    REG_DP       = 2'd2,
    REG_PRESCALE = 2'd3
  } reg_idx_e;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MASK_LSB = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
module seven_seg_decoder (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a small bus register bank.
// Digits are refreshed one slot at a time from a frame-stable shadow copy.
module sev_seg_scan_ctrl #(
  parameter int          N_DIGITS     = 8,
  parameter logic [15:0] PRESCALE_RST = 16'd50000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sel_i,
  input  logic                we_i,
  input  logic [1:0]          addr_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o,
  output logic                ack_o,
  output logic [N_DIGITS-1:0] an_o,
  output logic [6:0]          seg_o,
  output logic                dp_o
);
  import sev_seg_pkg::*;

  localparam int                DATA_W   = 4 * N_DIGITS;
  localparam int                IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [DATA_W-1:0]   r_data;
  logic                r_en;
  logic [N_DIGITS-1:0] r_mask;
  logic [N_DIGITS-1:0] r_dp;
  logic [15:0]         r_prescale;
  logic                r_ack;
  logic [31:0]         r_rdata;

  logic [15:0]         r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_blank;
  logic [DATA_W-1:0]   r_data_sh;
  logic [N_DIGITS-1:0] r_dp_sh;

  logic [N_DIGITS-1:0] r_an;
  logic [6:0]          r_seg;
  logic                r_dp_out;

  reg_idx_e            w_addr;
  logic                w_req;
  logic                w_wr;
  logic                w_wr_prescale;
  logic                w_tick;
  logic [31:0]         w_rd_val;
  logic [3:0]          w_nibble;
  logic [6:0]          w_seg;
  logic                w_show;
  logic [N_DIGITS-1:0] w_onehot;

  // A request landing in the ack cycle is dropped so every access gets one clean ack.
  assign w_addr        = reg_idx_e'(addr_i);
  assign w_req         = sel_i & ~r_ack;
  assign w_wr          = w_req & we_i;
  assign w_wr_prescale = w_wr && (w_addr == REG_PRESCALE);
  assign w_tick        = r_en && (r_cnt == r_prescale) && !w_wr_prescale;

  always_comb begin
    w_rd_val = '0;
    case (w_addr)
      REG_DATA:     w_rd_val[DATA_W-1:0] = r_data;
      REG_CTRL: begin
        w_rd_val[CTRL_EN]                       = r_en;
        w_rd_val[CTRL_MASK_LSB +: N_DIGITS]     = r_mask;
      end
      REG_DP:       w_rd_val[N_DIGITS-1:0] = r_dp;
      REG_PRESCALE: w_rd_val[15:0]         = r_prescale;
      default:      w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data     <= '0;
      r_en       <= 1'b0;
      r_mask     <= '0;
      r_dp       <= '0;
      r_prescale <= PRESCALE_RST;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= (w_req && !we_i) ? w_rd_val : '0;
      if (w_wr) begin
        case (w_addr)
          REG_DATA:     r_data <= wdata_i[DATA_W-1:0];
          REG_CTRL: begin
            r_en   <= wdata_i[CTRL_EN];
            r_mask <= wdata_i[CTRL_MASK_LSB +: N_DIGITS];
          end
          REG_DP:       r_dp       <= wdata_i[N_DIGITS-1:0];
          REG_PRESCALE: r_prescale <= wdata_i[15:0];
          default:      ;
        endcase
      end
    end
  end

  // Shadows only move at the frame boundary (or freely while disabled) to avoid tearing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_blank   <= 1'b0;
      r_data_sh <= '0;
      r_dp_sh   <= '0;
    end else begin
      if (!r_en) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else begin
        r_cnt <= (w_wr_prescale || w_tick) ? 16'd0 : r_cnt + 16'd1;
        if (w_tick) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
      r_blank <= w_tick & ~r_blank;
      if (!r_en || (w_tick && r_idx == LAST_IDX)) begin
        r_data_sh <= r_data;
        r_dp_sh   <= r_dp;
      end
    end
  end

  always_comb begin
    w_nibble = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_nibble = r_data_sh[4*i +: 4];
    end
  end

  seven_seg_decoder u_decoder (
    .i_hex (w_nibble),
    .o_seg (w_seg)
  );

  assign w_show   = r_en & ~r_blank & r_mask[r_idx];
  assign w_onehot = N_DIGITS'(1) << r_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_an     <= '1;
      r_seg    <= SEG_OFF;
      r_dp_out <= 1'b1;
    end else begin
      r_an     <= w_show ? ~w_onehot : '1;
      r_seg    <= w_show ? w_seg : SEG_OFF;
      r_dp_out <= w_show ? ~r_dp_sh[r_idx] : 1'b1;
    end
  end

  assign an_o    = r_an;
  assign seg_o   = r_seg;
  assign dp_o    = r_dp_out;
  assign ack_o   = r_ack;
  assign rdata_o = r_rdata;

endmodule
